// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared hex font table, segment-off constant and sizing helper for the FND scan controller
package fnd_pkg;

  // Active-high segment patterns, bit order g,f,e,d,c,b,a.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_OFF = 8'h00;

  // Bits needed to count 0..n-1; never less than one so counters stay declarable.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fnd_hex_decoder.sv
// rtl/fnd_hex_decoder.sv - combinational nibble to active-high 7-segment pattern
module fnd_hex_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_FONT[i_nibble];

endmodule

// File: rtl/fnd_scan_controller.sv
// rtl/fnd_scan_controller.sv - multiplexed 7-segment scan driver with double-buffered value,
// leading-zero blanking, per-digit decimal point and blink
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLINK_DIV      = 64,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
  input  logic [NUM_DIGITS-1:0]   i_blink_en,
  output logic [7:0]              o_fnd,
  output logic [NUM_DIGITS-1:0]   o_fnd_sel,
  output logic                    o_frame_done
);

  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam int PRE_W = clog2(REFRESH_DIV);
  localparam int BLK_W = clog2(BLINK_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_DIV - 1);

  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      act_val_q, act_val_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [VAL_W-1:0]      pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  blink_ph_q, blink_ph_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  frame_end;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic                  cur_blink;
  logic [6:0]            font_seg;

  fnd_hex_decoder u_dec (
    .i_nibble (cur_nib),
    .o_seg    (font_seg)
  );

  always_comb begin
    tick      = (presc_q == LAST_PRE);
    frame_end = tick && (idx_q == LAST_IDX);

    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    // Boundary transfer reads the old pending; a coincident load then refills it.
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    if (frame_end && pend_valid_q) begin
      act_val_d    = pend_val_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    if (i_load) begin
      pend_val_d   = i_value;
      pend_dp_d    = i_dp;
      pend_valid_d = 1'b1;
    end

    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (frame_end) begin
      if (blink_cnt_q == LAST_BLK) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  // lz_mask[k] is set when every active nibble from the top down to k is zero.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (act_val_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_lz    = 1'b0;
    cur_blink = 1'b0;
    sel_d     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = act_val_q[4*k +: 4];
        cur_dp    = act_dp_q[k];
        cur_lz    = lz_mask[k] && (k != 0);
        cur_blink = i_blink_en[k];
        sel_d[k]  = 1'b1;
      end
    end

    seg_d = {cur_dp, (i_blank_lz && cur_lz) ? 7'h00 : font_seg};
    if (blink_ph_q && cur_blink) seg_d = SEG_OFF;

    frame_done_d = frame_end;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      blink_ph_q   <= 1'b0;
      blink_cnt_q  <= '0;
      seg_q        <= SEG_OFF;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      blink_ph_q   <= blink_ph_d;
      blink_cnt_q  <= blink_cnt_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Registers hold logical (active-high) values; pin polarity is a pure output inversion.
  assign o_fnd        = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
  assign o_fnd_sel    = SEL_ACTIVE_LOW ? ~sel_q : sel_q;
  assign o_frame_done = frame_done_q;

endmodule
